mmio_mem_subsystem: RTL and testbench

// - Processor data-memory subsystem: 4096x32 dual-port data RAM plus memory-mapped I/O window.
// - Port A serves processor lw/sw; port B is a read-only VGA framebuffer port.
// - MMIO: keyboard scancode at 4100; player0 x/y/vel registers at 4200/4201/4202, exported to video logic.
// - Sits between processor and dmem/VGA/PS2 blocks; replaces tri-state muxing with a registered read mux.

---
 rtl/mmio_mem_subsystem.sv | 130 +++++++++++++
 tb/tb_mmio_mem_subsystem.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_mem_subsystem.sv
// Data-memory subsystem: 4096x32 dual-port RAM plus MMIO window (keyboard, player0).
// Define KBD_LATCH_EN to latch keyboard scancodes with clear-on-read; default reads ps2_out live.
module mmio_mem_subsystem #(
  parameter int          ADDR_W   = 13,
  parameter int          RAM_AW   = 12,
  parameter int          KBD_ADDR = 4100,
  parameter int          P0_BASE  = 4200,
  parameter logic [31:0] P0_X_RST = 32'd240
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_proc_addr,
  input  logic [31:0]       i_proc_wdata,
  input  logic              i_proc_wren,
  output logic [31:0]       o_proc_rdata,
  input  logic [RAM_AW-1:0] i_vga_addr,
  output logic [31:0]       o_vga_rdata,
  input  logic              i_ps2_key_pressed,
  input  logic [7:0]        i_ps2_out,
  output logic [31:0]       o_player0_x,
  output logic [31:0]       o_player0_y,
  output logic [31:0]       o_player0_vel
);

  logic [31:0]       r_mem [0:(2**RAM_AW)-1];
  logic [31:0]       r_proc_rdata;
  logic [31:0]       r_vga_rdata;
  logic [31:0]       r_p0_x;
  logic [31:0]       r_p0_y;
  logic [31:0]       r_p0_vel;
  logic [7:0]        w_kbd;
  logic [31:0]       w_rd_next;
  logic              w_sel_ram;
  logic              w_sel_kbd;
  logic              w_sel_p0x;
  logic              w_sel_p0y;
  logic              w_sel_p0v;
  logic [RAM_AW-1:0] w_ram_idx;

  // Full-width exact address decode; nothing aliases into the RAM or MMIO.
  assign w_sel_ram = i_proc_addr < ADDR_W'(2**RAM_AW);
  assign w_sel_kbd = i_proc_addr == ADDR_W'(KBD_ADDR);
  assign w_sel_p0x = i_proc_addr == ADDR_W'(P0_BASE);
  assign w_sel_p0y = i_proc_addr == ADDR_W'(P0_BASE + 1);
  assign w_sel_p0v = i_proc_addr == ADDR_W'(P0_BASE + 2);
  assign w_ram_idx = i_proc_addr[RAM_AW-1:0];

  // Port A store; RAM is not cleared by reset but a store during reset is dropped.
  always_ff @(posedge i_clock) begin
    if (!i_reset && i_proc_wren && w_sel_ram) begin
      r_mem[w_ram_idx] <= i_proc_wdata;
    end
  end

  // Port B: read-only framebuffer fetch, one cycle latency.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_vga_rdata <= '0;
    end else begin
      r_vga_rdata <= r_mem[i_vga_addr];
    end
  end

  // Player0 registers; only the addressed one takes the store.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_p0_x   <= P0_X_RST;
      r_p0_y   <= P0_X_RST;
      r_p0_vel <= '0;
    end else if (i_proc_wren) begin
      if (w_sel_p0x) r_p0_x   <= i_proc_wdata;
      if (w_sel_p0y) r_p0_y   <= i_proc_wdata;
      if (w_sel_p0v) r_p0_vel <= i_proc_wdata;
    end
  end

`ifdef KBD_LATCH_EN
  logic [7:0] r_kbd;
  logic       w_kbd_load;

  assign w_kbd_load = w_sel_kbd && !i_proc_wren;

  // Scancode latch: a fresh strobe beats the clear-on-read of the old code.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_kbd <= '0;
    end else if (i_ps2_key_pressed) begin
      r_kbd <= i_ps2_out;
    end else if (w_kbd_load) begin
      r_kbd <= '0;
    end
  end

  assign w_kbd = r_kbd;
`else
  logic w_unused_strobe;

  assign w_unused_strobe = i_ps2_key_pressed;
  assign w_kbd           = i_ps2_out;
`endif

  // Read source select; registers give old data when stored to in the same cycle.
  always_comb begin
    w_rd_next = '0;
    unique case (1'b1)
      w_sel_ram: w_rd_next = r_mem[w_ram_idx];
      w_sel_kbd: w_rd_next = {24'd0, w_kbd};
      w_sel_p0x: w_rd_next = r_p0_x;
      w_sel_p0y: w_rd_next = r_p0_y;
      w_sel_p0v: w_rd_next = r_p0_vel;
      default:   w_rd_next = '0;
    endcase
  end

  // Registered load data replaces the old tri-state bus.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_proc_rdata <= '0;
    end else begin
      r_proc_rdata <= w_rd_next;
    end
  end

  assign o_proc_rdata  = r_proc_rdata;
  assign o_vga_rdata   = r_vga_rdata;
  assign o_player0_x   = r_p0_x;
  assign o_player0_y   = r_p0_y;
  assign o_player0_vel = r_p0_vel;

endmodule

// File: tb/tb_mmio_mem_subsystem.sv
// Bench for mmio_mem_subsystem: vector table plus hand sequences,
// load results checked through an expected-value queue.
module tb_mmio_mem_subsystem;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] addr;
  logic [31:0] wdata;
  logic        wren;
  logic [31:0] rdata;
  logic [11:0] vaddr;
  logic [31:0] vdata;
  logic        kp;
  logic [7:0]  kout;
  logic [31:0] p0x;
  logic [31:0] p0y;
  logic [31:0] p0v;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic        is_vga;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];

  typedef struct {
    string       name;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [11:0] vaddr;
    logic        chk;
    logic [31:0] exp;
    logic        vchk;
    logic [31:0] vexp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mmio_mem_subsystem dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_proc_addr      (addr),
    .i_proc_wdata     (wdata),
    .i_proc_wren      (wren),
    .o_proc_rdata     (rdata),
    .i_vga_addr       (vaddr),
    .o_vga_rdata      (vdata),
    .i_ps2_key_pressed(kp),
    .i_ps2_out        (kout),
    .o_player0_x      (p0x),
    .o_player0_y      (p0y),
    .o_player0_vel    (p0v)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive, queue expectations, clock, compare what comes out.
  task automatic step(input string nm, input logic [12:0] a,
                      input logic [31:0] wd, input logic we,
                      input logic [11:0] va, input logic chk,
                      input logic [31:0] exp, input logic vchk,
                      input logic [31:0] vexp);
    sb_t e;
    addr  = a;
    wdata = wd;
    wren  = we;
    vaddr = va;
    if (chk) begin
      e.name = nm; e.is_vga = 1'b0; e.exp = exp;
      sbq.push_back(e);
    end
    if (vchk) begin
      e.name = {nm, "_vga"}; e.is_vga = 1'b1; e.exp = vexp;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.is_vga) check(e.name, vdata, e.exp);
      else          check(e.name, rdata, e.exp);
    end
    wren = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [12:0] a,
                    input logic [31:0] exp);
    step(nm, a, 32'd0, 1'b0, 12'd0, 1'b1, exp, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [12:0] a, input logic [31:0] d);
    step("wr", a, d, 1'b1, 12'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic addv(input string nm, input logic [12:0] a,
                      input logic [31:0] wd, input logic we,
                      input logic [11:0] va, input logic chk,
                      input logic [31:0] exp, input logic vchk,
                      input logic [31:0] vexp);
    vec_t v;
    v.name = nm; v.addr = a; v.wdata = wd; v.wren = we; v.vaddr = va;
    v.chk = chk; v.exp = exp; v.vchk = vchk; v.vexp = vexp;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; wren = 1'b0;
    vaddr = '0; kp = 1'b0; kout = 8'h00;

    addv("rd_p0x_rst", 13'd4200, 0, 0, 0, 1, 32'd240, 0, 0);
    addv("rd_p0y_rst", 13'd4201, 0, 0, 0, 1, 32'd240, 0, 0);
    addv("rd_p0v_rst", 13'd4202, 0, 0, 0, 1, 32'd0, 0, 0);
    addv("sw_17",      13'd17, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0);
    addv("lw_17",      13'd17, 0, 0, 12'd17, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    addv("sw_p0y_old", 13'd4201, 32'd5, 1, 0, 1, 32'd240, 0, 0);
    addv("lw_p0y_new", 13'd4201, 0, 0, 0, 1, 32'd5, 0, 0);
    addv("sw_kbd_ign", 13'd4100, 32'h77, 1, 0, 1, 32'd0, 0, 0);
    addv("rd_4150",    13'd4150, 0, 0, 0, 1, 32'd0, 0, 0);
    addv("rd_4103",    13'd4103, 0, 0, 0, 1, 32'd0, 0, 0);
    addv("sw_0",       13'd0, 32'h1234, 1, 0, 0, 0, 0, 0);
    addv("sw_4096",    13'd4096, 32'hBAD, 1, 0, 1, 32'd0, 0, 0);
    addv("lw_0_noalias", 13'd0, 0, 0, 0, 1, 32'h1234, 0, 0);
    addv("sw_4095",    13'd4095, 32'hA5, 1, 0, 0, 0, 0, 0);
    addv("lw_4095",    13'd4095, 0, 0, 12'd4095, 1, 32'hA5, 1, 32'hA5);
    addv("sw_3_old",   13'd3, 32'h22, 1, 0, 0, 0, 0, 0);
    addv("rbw_3",      13'd3, 32'h11, 1, 12'd3, 1, 32'h22, 1, 32'h22);
    addv("lw_3_new",   13'd3, 0, 0, 12'd3, 1, 32'h11, 1, 32'h11);
    addv("sw_p0x",     13'd4200, 32'd100, 1, 0, 1, 32'd240, 0, 0);
    addv("lw_p0x",     13'd4200, 0, 0, 0, 1, 32'd100, 0, 0);
    addv("sw_p0v",     13'd4202, 32'hFFFFFFF9, 1, 0, 1, 32'd0, 0, 0);
    addv("lw_p0v",     13'd4202, 0, 0, 0, 1, 32'hFFFFFFF9, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_vga", vdata, 32'd0);
    check("rst_p0x", p0x, 32'd240);
    check("rst_p0y", p0y, 32'd240);
    check("rst_p0v", p0v, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].name, vecs[i].addr, vecs[i].wdata, vecs[i].wren,
           vecs[i].vaddr, vecs[i].chk, vecs[i].exp,
           vecs[i].vchk, vecs[i].vexp);
      if (vecs[i].name == "lw_p0y_new") begin
        check("p0y_out", p0y, 32'd5);
        check("p0x_hold", p0x, 32'd240);
      end
    end
    check("p0x_out", p0x, 32'd100);
    check("p0v_out", p0v, 32'hFFFFFFF9);

`ifdef KBD_LATCH_EN
    kout = 8'h1C; kp = 1'b1;
    step("kbd_strobe", 13'd0, 0, 0, 0, 0, 0, 0, 0);
    kp = 1'b0; kout = 8'h55;
    rd("kbd_lw1", 13'd4100, 32'h1C);
    rd("kbd_lw2_clr", 13'd4100, 32'd0);
    kout = 8'h2A; kp = 1'b1;
    rd("kbd_coincide", 13'd4100, 32'd0);
    kp = 1'b0; kout = 8'h00;
    rd("kbd_new_kept", 13'd4100, 32'h2A);
`else
    kout = 8'h1C;
    rd("kbd_live1", 13'd4100, 32'h1C);
    kout = 8'h3D; kp = 1'b1;
    rd("kbd_live2", 13'd4100, 32'h3D);
    kp = 1'b0; kout = 8'h00;
`endif

    wr(13'd8, 32'hCAFE);
    wr(13'd9, 32'h99);
    rst = 1'b1;
    wr(13'd4200, 32'd999);
    check("rst_rdata2", rdata, 32'd0);
    wr(13'd9, 32'h66);
    rst = 1'b0;
    check("rst_p0x_drop", p0x, 32'd240);
    check("rst_p0y_again", p0y, 32'd240);
    check("rst_p0v_again", p0v, 32'd0);
    rd("ram_keep_8", 13'd8, 32'hCAFE);
    rd("ram_drop_9", 13'd9, 32'h99);
    rd("rd_p0x_post", 13'd4200, 32'd240);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
